taxi_fare_ctrl: RTL and testbench

TAXI_FARE_CTRL -- requirements
Module: taxi_fare_ctrl

---
 rtl/taxi_pkg.sv | 33 +++
 rtl/bcd_sat_add.sv | 20 ++
 rtl/taxi_fare_ctrl.sv | 161 ++++++++++++++++
 tb/tb_taxi_fare_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_pkg.sv
// rtl/taxi_pkg.sv - taxi fare controller shared state encoding, default fares and BCD helpers
package taxi_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } taxi_state_t;

   localparam int DEF_BASE_FARE = 10;
   localparam int DEF_BASE_DIST = 3;
   localparam int DEF_UNIT_RATE = 2;
   localparam int DEF_WAIT_RATE = 1;

   // Values up to 127 are accepted; callers clamp to 99 before converting.
   function automatic logic [7:0] bin_to_bcd2(input logic [6:0] v);
      logic [3:0] tens;
      logic [3:0] ones;
      tens = 4'(v / 7'd10);
      ones = 4'(v % 7'd10);
      return {tens, ones};
   endfunction

   function automatic logic [6:0] bcd2_to_bin(input logic [7:0] b);
      return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
   endfunction

   function automatic logic [9:0] bcd3_to_bin(input logic [11:0] b);
      return 10'(b[11:8]) * 10'd100 + 10'(b[7:4]) * 10'd10 + 10'(b[3:0]);
   endfunction

endpackage

// File: rtl/bcd_sat_add.sv
// rtl/bcd_sat_add.sv - combinational 2-digit BCD adder saturating at 99
module bcd_sat_add
   import taxi_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   output logic [7:0] sum
);

   logic [7:0] bin_sum;

   always_comb begin
      bin_sum = {1'b0, bcd2_to_bin(a)} + {1'b0, bcd2_to_bin(b)};
      if (bin_sum > 8'd99)
         sum = 8'h99;
      else
         sum = bin_to_bcd2(bin_sum[6:0]);
   end

endmodule

// File: rtl/taxi_fare_ctrl.sv
// rtl/taxi_fare_ctrl.sv - taxi meter: trip FSM, BCD distance/time counters, fare accumulation
// Optional macro TAXI_NIGHT_RATE_EN adds a night input raising the per-unit distance charge by 1.
module taxi_fare_ctrl
   import taxi_pkg::*;
#(
   parameter int BASE_FARE = DEF_BASE_FARE,
   parameter int BASE_DIST = DEF_BASE_DIST,
   parameter int UNIT_RATE = DEF_UNIT_RATE,
   parameter int WAIT_RATE = DEF_WAIT_RATE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        stop,
   input  logic        wait_req,
   input  logic        clr,
   input  logic        dist_pulse,
   input  logic        tick_1hz,
`ifdef TAXI_NIGHT_RATE_EN
   input  logic        night,
`endif
   output logic [11:0] distance,
   output logic [3:0]  m,
   output logic [7:0]  s,
   output logic [7:0]  expense,
   output logic [1:0]  state
);

   localparam logic [7:0] BASE_FARE_BCD = bin_to_bcd2(7'(BASE_FARE));
   localparam logic [6:0] UNIT_CHG      = 7'(UNIT_RATE);
   localparam logic [6:0] NIGHT_CHG     = 7'(UNIT_RATE + 1);
   localparam logic [6:0] WAIT_CHG      = 7'(WAIT_RATE);

   taxi_state_t state_q, state_d;
   logic [5:0]  wait_sec;

   logic        trip_start;
   logic        trip_clr;
   logic        trip_active;
   logic        dist_count;
   logic        dist_chg;
   logic        wait_tick;
   logic        wait_wrap;
   logic [6:0]  dist_rate;
   logic [6:0]  add_bin;
   logic [7:0]  add_bcd;
   logic [7:0]  exp_sum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // In an active trip stop outranks start; in IDLE/DONE start outranks clr and stop.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_RUN;
         S_RUN: begin
            if (stop)          state_d = S_DONE;
            else if (wait_req) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (stop)           state_d = S_DONE;
            else if (!wait_req) state_d = S_RUN;
         end
         S_DONE: begin
            if (start)    state_d = S_RUN;
            else if (clr) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

`ifdef TAXI_NIGHT_RATE_EN
   assign dist_rate = night ? NIGHT_CHG : UNIT_CHG;
`else
   assign dist_rate = UNIT_CHG;
   logic unused_night_chg;
   assign unused_night_chg = ^NIGHT_CHG;
`endif

   // The cycle that enters WAIT already accrues waiting time, so a counted
   // distance pulse and a wait-minute rollover can land in the same cycle.
   always_comb begin
      trip_start  = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
      trip_clr    = (state_q == S_DONE) && clr && !start;
      trip_active = (state_q == S_RUN) || (state_q == S_WAIT);
      dist_count  = (state_q == S_RUN) && dist_pulse;
      dist_chg    = dist_count && (bcd3_to_bin(distance) >= 10'(BASE_DIST));
      wait_tick   = tick_1hz &&
                    ((state_q == S_WAIT) || ((state_q == S_RUN) && wait_req && !stop));
      wait_wrap   = wait_tick && (wait_sec == 6'd59);
      add_bin     = (dist_chg ? dist_rate : 7'd0) + (wait_wrap ? WAIT_CHG : 7'd0);
      add_bcd     = bin_to_bcd2((add_bin > 7'd99) ? 7'd99 : add_bin);
   end

   bcd_sat_add u_exp_add (
      .a   (expense),
      .b   (add_bcd),
      .sum (exp_sum)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         distance <= 12'h000;
         m        <= 4'd0;
         s        <= 8'h00;
         expense  <= 8'h00;
         wait_sec <= 6'd0;
      end else if (trip_start) begin
         distance <= 12'h000;
         m        <= 4'd0;
         s        <= 8'h00;
         expense  <= BASE_FARE_BCD;
         wait_sec <= 6'd0;
      end else if (trip_clr) begin
         distance <= 12'h000;
         m        <= 4'd0;
         s        <= 8'h00;
         expense  <= 8'h00;
         wait_sec <= 6'd0;
      end else if (trip_active) begin
         if (dist_count && (distance != 12'h999)) begin
            if (distance[3:0] != 4'd9) begin
               distance[3:0] <= distance[3:0] + 4'd1;
            end else begin
               distance[3:0] <= 4'd0;
               if (distance[7:4] != 4'd9) begin
                  distance[7:4] <= distance[7:4] + 4'd1;
               end else begin
                  distance[7:4]  <= 4'd0;
                  distance[11:8] <= distance[11:8] + 4'd1;
               end
            end
         end

         if (tick_1hz && !((m == 4'd9) && (s == 8'h59))) begin
            if (s == 8'h59) begin
               s <= 8'h00;
               m <= m + 4'd1;
            end else if (s[3:0] == 4'd9) begin
               s <= {s[7:4] + 4'd1, 4'd0};
            end else begin
               s <= s + 8'd1;
            end
         end

         if (wait_tick)
            wait_sec <= wait_wrap ? 6'd0 : wait_sec + 6'd1;

         if (dist_chg || wait_wrap)
            expense <= exp_sum;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_taxi_fare_ctrl.sv
// tb/tb_taxi_fare_ctrl.sv - directed self-checking bench for taxi_fare_ctrl
module tb_taxi_fare_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        stop;
   logic        wait_req;
   logic        clr;
   logic        dist_pulse;
   logic        tick_1hz;
`ifdef TAXI_NIGHT_RATE_EN
   logic        night;
`endif
   logic [11:0] distance;
   logic [3:0]  m;
   logic [7:0]  s;
   logic [7:0]  expense;
   logic [1:0]  state;

   int pass_cnt;
   int total_cnt;

   taxi_fare_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .stop       (stop),
      .wait_req   (wait_req),
      .clr        (clr),
      .dist_pulse (dist_pulse),
      .tick_1hz   (tick_1hz),
`ifdef TAXI_NIGHT_RATE_EN
      .night      (night),
`endif
      .distance   (distance),
      .m          (m),
      .s          (s),
      .expense    (expense),
      .state      (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One clock with the given pulses held high, then sampled 1 ns after the edge.
   task automatic cyc(input logic st, input logic sp, input logic dp,
                      input logic tk, input logic cl);
      start = st; stop = sp; dist_pulse = dp; tick_1hz = tk; clr = cl;
      @(posedge clk);
      #1;
      start = 1'b0; stop = 1'b0; dist_pulse = 1'b0; tick_1hz = 1'b0; clr = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total_cnt++;
      if ({state, distance, m, s, expense} !== 34'd0)
         $display("FAIL reset_state got st=%0d d=%h m=%h s=%h e=%h want all zero",
                  state, distance, m, s, expense);
      else pass_cnt++;
      rst_n = 1'b1;
      cyc(0, 1, 1, 1, 1);
      total_cnt++;
      if ({state, distance, m, s, expense} !== 34'd0)
         $display("FAIL idle_ignore got st=%0d d=%h m=%h s=%h e=%h want all zero",
                  state, distance, m, s, expense);
      else pass_cnt++;
   endtask

   task automatic test_distance;
      cyc(1, 0, 0, 0, 0);
      total_cnt++;
      if (state !== 2'd1 || expense !== 8'h10 || distance !== 12'h000)
         $display("FAIL start_load got st=%0d e=%h d=%h want st=1 e=10 d=000",
                  state, expense, distance);
      else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 1, 0, 0);
         cyc(0, 0, 0, 0, 0);
      end
      total_cnt++;
      if (distance !== 12'h003 || expense !== 8'h10)
         $display("FAIL base_dist got d=%h e=%h want d=003 e=10", distance, expense);
      else pass_cnt++;
      cyc(0, 0, 1, 0, 0);
      total_cnt++;
      if (distance !== 12'h004 || expense !== 8'h12)
         $display("FAIL first_unit got d=%h e=%h want d=004 e=12", distance, expense);
      else pass_cnt++;
      cyc(0, 0, 1, 0, 0);
      total_cnt++;
      if (distance !== 12'h005 || expense !== 8'h14)
         $display("FAIL dist5 got d=%h e=%h want d=005 e=14", distance, expense);
      else pass_cnt++;
   endtask

   task automatic test_wait;
      wait_req = 1'b1;
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      total_cnt++;
      if (state !== 2'd2 || expense !== 8'h10 || distance !== 12'h000)
         $display("FAIL enter_wait got st=%0d e=%h d=%h want st=2 e=10 d=000",
                  state, expense, distance);
      else pass_cnt++;
      cyc(0, 0, 1, 0, 0);
      total_cnt++;
      if (distance !== 12'h000)
         $display("FAIL wait_no_dist got d=%h want 000", distance);
      else pass_cnt++;
      for (int i = 0; i < 125; i++) begin
         cyc(0, 0, 0, 1, 0);
         cyc(0, 0, 0, 0, 0);
      end
      total_cnt++;
      if (m !== 4'd2 || s !== 8'h05 || expense !== 8'h12 || distance !== 12'h000)
         $display("FAIL wait125 got m=%h s=%h e=%h d=%h want m=2 s=05 e=12 d=000",
                  m, s, expense, distance);
      else pass_cnt++;
      wait_req = 1'b0;
      cyc(0, 0, 0, 0, 0);
      total_cnt++;
      if (state !== 2'd1)
         $display("FAIL leave_wait got st=%0d want 1", state);
      else pass_cnt++;
   endtask

   task automatic test_combined;
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
      wait_req = 1'b1;
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 59; i++) cyc(0, 0, 0, 1, 0);
      total_cnt++;
      if (state !== 2'd2 || expense !== 8'h10 || s !== 8'h59 || distance !== 12'h003)
         $display("FAIL wait59 got st=%0d e=%h s=%h d=%h want st=2 e=10 s=59 d=003",
                  state, expense, s, distance);
      else pass_cnt++;
      wait_req = 1'b0;
      cyc(0, 0, 0, 0, 0);
      wait_req = 1'b1;
      cyc(0, 0, 1, 1, 0);
      total_cnt++;
      if (expense !== 8'h13 || distance !== 12'h004 || m !== 4'd1 || s !== 8'h00 || state !== 2'd2)
         $display("FAIL both_chg got e=%h d=%h m=%h s=%h st=%0d want e=13 d=004 m=1 s=00 st=2",
                  expense, distance, m, s, state);
      else pass_cnt++;
      wait_req = 1'b0;
      cyc(0, 0, 0, 0, 0);
      for (int i = 0; i < 50; i++) cyc(0, 0, 1, 0, 0);
      total_cnt++;
      if (expense !== 8'h99 || distance !== 12'h054)
         $display("FAIL exp_sat got e=%h d=%h want e=99 d=054", expense, distance);
      else pass_cnt++;
   endtask

   task automatic test_start_stop;
      cyc(0, 0, 0, 0, 1);
      total_cnt++;
      if (state !== 2'd1)
         $display("FAIL clr_in_run got st=%0d want 1", state);
      else pass_cnt++;
      cyc(1, 1, 0, 0, 0);
      cyc(0, 0, 1, 1, 0);
      total_cnt++;
      if (state !== 2'd3 || expense !== 8'h99 || distance !== 12'h054 || m !== 4'd1 || s !== 8'h00)
         $display("FAIL done_hold got st=%0d e=%h d=%h m=%h s=%h want st=3 e=99 d=054 m=1 s=00",
                  state, expense, distance, m, s);
      else pass_cnt++;
      cyc(0, 0, 0, 0, 1);
      total_cnt++;
      if ({state, distance, m, s, expense} !== 34'd0)
         $display("FAIL clr_idle got st=%0d d=%h m=%h s=%h e=%h want all zero",
                  state, distance, m, s, expense);
      else pass_cnt++;
   endtask

   task automatic test_time_sat;
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 605; i++) cyc(0, 0, 0, 1, 0);
      total_cnt++;
      if (m !== 4'd9 || s !== 8'h59 || expense !== 8'h10)
         $display("FAIL time_sat got m=%h s=%h e=%h want m=9 s=59 e=10", m, s, expense);
      else pass_cnt++;
   endtask

   task automatic test_async_reset;
      cyc(0, 1, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({state, distance, m, s, expense} !== 34'd0)
         $display("FAIL async_rst got st=%0d d=%h m=%h s=%h e=%h want all zero",
                  state, distance, m, s, expense);
      else pass_cnt++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1, 0, 0, 0, 0);
      total_cnt++;
      if (state !== 2'd1 || expense !== 8'h10 || distance !== 12'h000 || s !== 8'h00)
         $display("FAIL restart got st=%0d e=%h d=%h s=%h want st=1 e=10 d=000 s=00",
                  state, expense, distance, s);
      else pass_cnt++;
   endtask

`ifdef TAXI_NIGHT_RATE_EN
   task automatic test_night;
      cyc(0, 1, 0, 0, 0);
      night = 1'b1;
      cyc(1, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 0);
      total_cnt++;
      if (expense !== 8'h16 || distance !== 12'h005)
         $display("FAIL night5 got e=%h d=%h want e=16 d=005", expense, distance);
      else pass_cnt++;
      night = 1'b0;
   endtask
`endif

   initial begin
      pass_cnt   = 0;
      total_cnt  = 0;
      rst_n      = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      wait_req   = 1'b0;
      clr        = 1'b0;
      dist_pulse = 1'b0;
      tick_1hz   = 1'b0;
`ifdef TAXI_NIGHT_RATE_EN
      night      = 1'b0;
`endif
      test_reset();
      test_distance();
      cyc(0, 1, 0, 0, 0);
      test_wait();
      test_combined();
      test_start_stop();
      test_time_sat();
      test_async_reset();
`ifdef TAXI_NIGHT_RATE_EN
      test_night();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
